// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Transmit half of the serial link. A byte offered on a valid/ready handshake
// is serialised onto the line as:
//   start bit (0), 8 data bits LSB first, optional even-parity bit,
//   STOP_BITS stop bits (1).
// The block owns its baud-rate counter, so no external baud enable is needed.
// The parity bit is the XOR of the 8 data bits, matching the receiver.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   PARITY_EN     1 = append parity bit, 0 = no parity bit
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   tx_data   in   byte to send, sampled only on the accept cycle
//   tx_valid  in   tx_data is valid
//   tx_ready  out  block can accept a byte (IDLE only)
//   tx        out  serial line, registered, idles high
//   tx_busy   out  a frame is in progress
//   tx_done   out  one-cycle pulse after the last stop bit completes
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int                BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        DATA_LAST  = 3'd7;
  localparam logic [2:0]        STOP_LAST  = 3'(STOP_BITS - 1);
  localparam bit                HAS_PARITY = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_next;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_next;
  logic [7:0]        shift;
  logic [7:0]        shift_next;
  logic              parity;
  logic              parity_next;
  logic              tx_next;
  logic              done_next;
  logic              bit_end;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  // Line level that a given state presents on tx.
  function automatic logic line_level(input state_t s, input logic data_bit,
                                      input logic par_bit);
    logic lvl;
    lvl = 1'b1;
    case (s)
      IDLE:    lvl = 1'b1;
      START:   lvl = 1'b0;
      DATA:    lvl = data_bit;
      PARITY:  lvl = par_bit;
      STOP:    lvl = 1'b1;
      default: lvl = 1'b1;
    endcase
    return lvl;
  endfunction

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);

  // State, counters and line register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      parity   <= parity_next;
      tx       <= tx_next;
      tx_done  <= done_next;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    state_next  = state;
    baud_next   = baud_cnt;
    bit_next    = bit_cnt;
    shift_next  = shift;
    parity_next = parity;
    done_next   = 1'b0;

    case (state)
      IDLE: begin
        baud_next = '0;
        bit_next  = '0;
        if (tx_valid) begin
          shift_next  = tx_data;
          parity_next = even_parity(tx_data);
          state_next  = START;
        end
      end

      START: begin
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_next  = '0;
          shift_next = {1'b0, shift[7:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_next   = '0;
            state_next = HAS_PARITY ? PARITY : STOP;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end

      PARITY: begin
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = STOP;
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          baud_next = '0;
          // bit_cnt counts completed stop bits within this state.
          if (bit_cnt == STOP_LAST) begin
            bit_next   = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end

      default: begin
        // Unreachable encodings recover to an idle, high line.
        state_next = IDLE;
        baud_next  = '0;
        bit_next   = '0;
      end
    endcase

    // tx is registered from the state being entered, so the line changes on
    // the same edge as the state and never glitches.
    tx_next = line_level(state_next, shift_next[0], parity_next);
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int PAR_A = 1;
  localparam int STP_A = 1;
  localparam int PAR_B = 0;
  localparam int STP_B = 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int passed;
  int total;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(PAR_A), .STOP_BITS(STP_A)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (data_a),
    .tx_valid (valid_a),
    .tx_ready (ready_a),
    .tx       (tx_a),
    .tx_busy  (busy_a),
    .tx_done  (done_a)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(PAR_B), .STOP_BITS(STP_B)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (data_b),
    .tx_valid (valid_b),
    .tx_ready (ready_b),
    .tx       (tx_b),
    .tx_busy  (busy_b),
    .tx_done  (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // {tx, tx_ready, tx_busy, tx_done}
  function automatic logic [3:0] outs(input int which);
    return (which == 0) ? {tx_a, ready_a, busy_a, done_a} : {tx_b, ready_b, busy_b, done_b};
  endfunction

  task automatic set_in(input int which, input logic v, input logic [7:0] d);
    if (which == 0) begin
      valid_a = v;
      data_a  = d;
    end else begin
      valid_b = v;
      data_b  = d;
    end
  endtask

  // Called on a negedge while the DUT is idle; returns on the negedge after
  // the accepting edge.
  task automatic launch(input int which, input logic [7:0] d, input bit hold);
    logic [3:0] o;
    set_in(which, 1'b1, d);
    o = outs(which);
    check($sformatf("ready_before_%0d", which), {7'b0, o[2]}, 8'h01);
    @(negedge clk);
    if (!hold) set_in(which, 1'b0, 8'h00);
  endtask

  // Reference model: expected line as a list of bit levels, each held CPB
  // cycles, followed by one done cycle.
  task automatic run_frame(input int which, input logic [7:0] d, input int abort_at,
                           input bit disturb);
    bit bits[$];
    int par_en;
    int stops;
    int ncyc;
    par_en = (which == 0) ? PAR_A : PAR_B;
    stops  = (which == 0) ? STP_A : STP_B;
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(d[k]);
    if (par_en != 0) bits.push_back(bit'($countones(d) % 2));
    for (int k = 0; k < stops; k++) bits.push_back(1'b1);
    ncyc = bits.size() * CPB;
    for (int i = 0; i < ncyc; i++) begin
      if (i == abort_at) return;
      check($sformatf("frame%0d_%02h_c%0d", which, d, i), {4'b0, outs(which)},
            {4'b0, bits[i / CPB], 3'b010});
      if (disturb && i == 10) set_in(which, 1'b1, 8'hAA);
      if (disturb && i == 20) set_in(which, 1'b0, 8'hAA);
      @(negedge clk);
    end
    check($sformatf("done%0d_%02h", which, d), {4'b0, outs(which)}, 8'b0000_1101);
  endtask

  initial begin
    logic [7:0] rd;
    int         wh;
    passed  = 0;
    total   = 0;
    rst_n   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    data_a  = 8'h00;
    data_b  = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_a", {4'b0, outs(0)}, 8'b0000_1100);
    check("reset_b", {4'b0, outs(1)}, 8'b0000_1100);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle_a_%0d", i), {4'b0, outs(0)}, 8'b0000_1100);
      check($sformatf("idle_b_%0d", i), {4'b0, outs(1)}, 8'b0000_1100);
    end

    // Single byte with parity
    launch(0, 8'hA5, 1'b0);
    run_frame(0, 8'hA5, -1, 1'b0);
    @(negedge clk);
    check("after_a5", {4'b0, outs(0)}, 8'b0000_1100);

    // Parity cases
    launch(0, 8'h01, 1'b0); run_frame(0, 8'h01, -1, 1'b0); @(negedge clk);
    launch(0, 8'h00, 1'b0); run_frame(0, 8'h00, -1, 1'b0); @(negedge clk);
    launch(0, 8'hFF, 1'b0); run_frame(0, 8'hFF, -1, 1'b0); @(negedge clk);

    // Back-to-back with tx_valid held
    launch(0, 8'h3C, 1'b1);
    set_in(0, 1'b1, 8'hC3);
    run_frame(0, 8'h3C, -1, 1'b0);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00);
    run_frame(0, 8'hC3, -1, 1'b0);
    @(negedge clk);
    check("after_b2b", {4'b0, outs(0)}, 8'b0000_1100);

    // Input changes mid-frame are ignored
    launch(0, 8'h55, 1'b0);
    run_frame(0, 8'h55, -1, 1'b1);
    @(negedge clk);
    check("after_stab", {4'b0, outs(0)}, 8'b0000_1100);

    // Reset during DATA
    launch(0, 8'h96, 1'b0);
    run_frame(0, 8'h96, 3 * CPB + 2, 1'b0);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_a", {4'b0, outs(0)}, 8'b0000_1100);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_%0d", i), {4'b0, outs(0)}, 8'b0000_1100);
    end
    launch(0, 8'h5A, 1'b0); run_frame(0, 8'h5A, -1, 1'b0); @(negedge clk);

    // No parity, two stop bits
    launch(1, 8'hA5, 1'b0); run_frame(1, 8'hA5, -1, 1'b0); @(negedge clk);
    check("after_b_a5", {4'b0, outs(1)}, 8'b0000_1100);

    // Random bytes on both configurations
    for (int n = 0; n < 10; n++) begin
      wh = int'($urandom_range(0, 1));
      rd = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      launch(wh, rd, 1'b0);
      run_frame(wh, rd, -1, 1'b0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
